// File: rtl/module_bcd_display_mux_pkg.sv
// Shared 7-segment types and active-high segment patterns ({g,f,e,d,c,b,a}, bit0 = a).
package seg7_pkg;

    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK   = 7'h00;
    localparam logic [6:0] SEG_DASH    = 7'h40;

    localparam logic [6:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h6F;

endpackage

// File: rtl/module_bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment pattern; non-BCD nibbles show a dash.
module module_bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pat
);

    always_comb begin
        o_pat = SEG_DASH;
        case (i_nibble)
            4'd0:    o_pat = SEG_DIGIT_0;
            4'd1:    o_pat = SEG_DIGIT_1;
            4'd2:    o_pat = SEG_DIGIT_2;
            4'd3:    o_pat = SEG_DIGIT_3;
            4'd4:    o_pat = SEG_DIGIT_4;
            4'd5:    o_pat = SEG_DIGIT_5;
            4'd6:    o_pat = SEG_DIGIT_6;
            4'd7:    o_pat = SEG_DIGIT_7;
            4'd8:    o_pat = SEG_DIGIT_8;
            4'd9:    o_pat = SEG_DIGIT_9;
            default: o_pat = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/module_bcd_display_mux.sv
// Latches a packed 4-digit BCD word and time-multiplexes it onto a 4-digit 7-segment display.
// Optional leading-zero blanking: define SEG_LEADING_ZERO_BLANK_EN.
module module_bcd_display_mux
    import seg7_pkg::*;
#(
    parameter int unsigned REFRESH_DIV    = 27000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_bcd,
    input  logic        i_load,
    output logic [6:0]  o_seg,
    output logic [3:0]  o_an,
    output logic        o_frame
);

    localparam int unsigned      DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]       AN_OFF   = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    scan_state_e      state_q, state_d;
    logic [15:0]      bcd_disp_q, bcd_disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_q, frame_d;

    logic             tick;
    logic             wrap;
    logic [3:0]       nibble;
    logic [6:0]       pat;
    logic [3:0]       lead_zero;
    logic [3:0]       an_onehot;

    assign tick = (div_cnt_q == DIV_LAST);
    assign wrap = (state_q == DIG3);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_cnt_q  <= '0;
            state_q    <= DIG3;
            bcd_disp_q <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_OFF;
            an_q       <= AN_OFF;
            frame_q    <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            bcd_disp_q <= bcd_disp_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            frame_q    <= frame_d;
        end
    end

    // Scan sequencing and frame-boundary capture; a load coinciding with the boundary bypasses pend.
    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        state_d    = state_q;
        bcd_disp_d = bcd_disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        frame_d    = 1'b0;

        if (i_load) begin
            pend_d     = i_bcd;
            pend_vld_d = 1'b1;
        end

        if (tick) begin
            case (state_q)
                DIG0:    state_d = DIG1;
                DIG1:    state_d = DIG2;
                DIG2:    state_d = DIG3;
                default: state_d = DIG0;
            endcase
            if (wrap) begin
                bcd_disp_d = i_load ? i_bcd : (pend_vld_q ? pend_q : bcd_disp_q);
                pend_vld_d = 1'b0;
                frame_d    = 1'b1;
            end
        end
    end

    assign nibble = bcd_disp_d[{state_d, 2'b00} +: 4];

    module_bcd_to_seg7 u_dec (
        .i_nibble (nibble),
        .o_pat    (pat)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin
        lead_zero[3] = (bcd_disp_d[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (bcd_disp_d[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (bcd_disp_d[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
    end
`else
    assign lead_zero = '0;
`endif

    assign an_onehot = 4'b0001 << state_d;

    always_comb begin
        seg_d = seg_q;
        an_d  = an_q;
        if (tick) begin
            if (lead_zero[state_d]) begin
                seg_d = SEG_OFF;
                an_d  = AN_OFF;
            end else begin
                seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
                an_d  = AN_ACTIVE_LOW ? ~an_onehot : an_onehot;
            end
        end
    end

    assign o_seg   = seg_q;
    assign o_an    = an_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_module_bcd_display_mux.sv
// Directed, table-driven bench for module_bcd_display_mux (REFRESH_DIV = 4, active-low segments/anodes).
module tb_module_bcd_display_mux;

    localparam int unsigned RD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic        load;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    module_bcd_display_mux #(
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_bcd   (bcd),
        .i_load  (load),
        .o_seg   (seg),
        .o_an    (an),
        .o_frame (frame)
    );

    // seg = {thousands, hundreds, tens, ones} active-low patterns; blank = digits that
    // leading-zero blanking would switch off.
    typedef struct packed {
        logic [15:0] bcd;
        logic [27:0] seg;
        logic [3:0]  blank;
    } vec_t;

    vec_t vecs [6];
    vec_t v_zero, v_2222, v_9999;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] an_exp(input int k, input logic [3:0] blank);
        logic [3:0] oh;
        oh = 4'b0001 << k;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (blank[k]) return 4'hF;
`endif
        return ~oh;
    endfunction

    function automatic logic [6:0] seg_exp(input int k, input vec_t v);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (v.blank[k]) return 7'h7F;
`endif
        return v.seg[k*7 +: 7];
    endfunction

    task automatic chk_off(input string tag);
        chk({tag, " an off"}, an, 4'hF);
        chk({tag, " seg off"}, seg, 7'h7F);
        chk({tag, " frame low"}, frame, 1'b0);
    endtask

    // Entered on the o_frame cycle; leaves just after the digit-3 slot starts.
    task automatic check_slots(input string tag, input vec_t v);
        chk({tag, " frame"}, frame, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                if (k == 1) begin
                    step();
                    chk({tag, " frame pulse width"}, frame, 1'b0);
                    repeat (RD - 1) step();
                end else begin
                    repeat (RD) step();
                end
            end
            chk($sformatf("%s an slot%0d", tag, k), an, an_exp(k, v.blank));
            chk($sformatf("%s seg slot%0d", tag, k), seg, seg_exp(k, v));
        end
    endtask

    task automatic wait_frame(input string tag);
        int n = 0;
        while (frame !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (frame !== 1'b1) chk({tag, " frame timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        vecs[0] = '{bcd: 16'h1234, seg: {7'h79, 7'h24, 7'h30, 7'h19}, blank: 4'b0000};
        vecs[1] = '{bcd: 16'h00A7, seg: {7'h40, 7'h40, 7'h3F, 7'h78}, blank: 4'b1100};
        vecs[2] = '{bcd: 16'h0050, seg: {7'h40, 7'h40, 7'h12, 7'h40}, blank: 4'b1100};
        vecs[3] = '{bcd: 16'h0000, seg: {7'h40, 7'h40, 7'h40, 7'h40}, blank: 4'b1110};
        vecs[4] = '{bcd: 16'h8906, seg: {7'h00, 7'h10, 7'h40, 7'h02}, blank: 4'b0000};
        vecs[5] = '{bcd: 16'hF00F, seg: {7'h3F, 7'h40, 7'h40, 7'h3F}, blank: 4'b0000};
        v_zero  = '{bcd: 16'h0000, seg: {7'h40, 7'h40, 7'h40, 7'h40}, blank: 4'b1110};
        v_2222  = '{bcd: 16'h2222, seg: {7'h24, 7'h24, 7'h24, 7'h24}, blank: 4'b0000};
        v_9999  = '{bcd: 16'h9999, seg: {7'h10, 7'h10, 7'h10, 7'h10}, blank: 4'b0000};

        rst_n = 1'b0;
        load  = 1'b0;
        bcd   = '0;
        repeat (3) step();
        chk_off("reset");

        // First lit slot appears RD cycles after release.
        rst_n = 1'b1;
        for (int i = 1; i < int'(RD); i++) begin
            step();
            chk_off($sformatf("post-reset c%0d", i));
        end
        step();
        check_slots("first frame", v_zero);

        for (int i = 0; i < 6; i++) begin
            vec_t prev;
            prev = (i == 0) ? v_zero : vecs[i-1];
            bcd  = vecs[i].bcd;
            load = 1'b1;
            step();
            load = 1'b0;
            chk($sformatf("v%0d hold an", i), an, an_exp(3, prev.blank));
            chk($sformatf("v%0d hold seg", i), seg, seg_exp(3, prev));
            wait_frame($sformatf("v%0d", i));
            check_slots($sformatf("v%0d", i), vecs[i]);
        end

        // Two loads in one frame: last one wins.
        bcd = 16'h1111; load = 1'b1; step();
        bcd = 16'h2222; load = 1'b1; step();
        load = 1'b0;
        wait_frame("double load");
        check_slots("double load", v_2222);

        // Load coincident with the wrap tick shows on that same boundary.
        repeat (RD - 1) step();
        bcd = 16'h9999; load = 1'b1;
        step();
        load = 1'b0;
        check_slots("wrap load", v_9999);
        wait_frame("wrap load next");
        check_slots("wrap load next", v_9999);

        // Reset with a pending value drops it.
        bcd = 16'h5555; load = 1'b1; step();
        load = 1'b0;
        rst_n = 1'b0;
        step();
        chk_off("mid reset");
        rst_n = 1'b1;
        for (int i = 1; i < int'(RD); i++) begin
            step();
            chk_off($sformatf("re-release c%0d", i));
        end
        step();
        check_slots("after reset", v_zero);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
